// File: rtl/jpc_pkg.sv
// Shared constants for the program-counter block.
//   XLEN_DEFAULT         : default PC/address width
//   RESET_VECTOR_DEFAULT : default PC value held during reset
//   PC_STEP              : sequential instruction stride in bytes
//   ALIGN_MASK           : low PC bits that must be zero for a legal target
package jpc_pkg;

    localparam int unsigned XLEN_DEFAULT         = 32;
    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
    localparam int unsigned PC_STEP              = 4;
    localparam int unsigned ALIGN_MASK           = 3;

endpackage : jpc_pkg

// File: rtl/jpc_pc_align_chk.sv
// Combinational alignment check on a candidate PC target.
// Compiled only when JPC_PC_MISALIGN_CHECK_EN is defined.
//   addr    : candidate target address
//   fault_c : 1 when any bit selected by ALIGN_MASK is set
`ifdef JPC_PC_MISALIGN_CHECK_EN
module jpc_pc_align_chk
    import jpc_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] addr,
    output logic            fault_c
);

    assign fault_c = |(addr & XLEN'(ALIGN_MASK));

endmodule : jpc_pc_align_chk
`endif

// File: rtl/jpc_pc.sv
// Program counter register with stall control.
// Optional feature macro: JPC_PC_MISALIGN_CHECK_EN (rejects unaligned targets).
//   clk          : clock, rising edge
//   rst          : asynchronous active-low reset
//   next_pc_I    : candidate next PC (sequential or branch target)
//   pc_enable_I  : 1 = load next_pc_I, 0 = hold
//   pc_O         : current PC (registered)
//   pc_plus4_O   : pc_O + 4, wraps modulo 2^XLEN (combinational)
//   pc_valid_O   : 1 from the first edge after reset release (registered)
//   misalign_O   : one-cycle fault pulse on an unaligned load (macro only)
//   fault_pc_O   : last rejected unaligned target (macro only)
module jpc_pc
    import jpc_pkg::*;
#(
    parameter int unsigned     XLEN         = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] next_pc_I,
    input  logic            pc_enable_I,
    output logic [XLEN-1:0] pc_O,
    output logic [XLEN-1:0] pc_plus4_O,
    output logic            pc_valid_O
`ifdef JPC_PC_MISALIGN_CHECK_EN
    ,
    output logic            misalign_O,
    output logic [XLEN-1:0] fault_pc_O
`endif
);

    logic load_c;

`ifdef JPC_PC_MISALIGN_CHECK_EN
    logic unaligned_c;

    jpc_pc_align_chk #(
        .XLEN    (XLEN)
    ) u_align_chk (
        .addr    (next_pc_I),
        .fault_c (unaligned_c)
    );

    // An unaligned target is rejected: the PC holds and the fault is reported.
    assign load_c = pc_enable_I & ~unaligned_c;

    // Fault pulse lasts one cycle; the captured target persists until the next fault.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misalign_O <= 1'b0;
            fault_pc_O <= '0;
        end else if (pc_enable_I && unaligned_c) begin
            misalign_O <= 1'b1;
            fault_pc_O <= next_pc_I;
        end else begin
            misalign_O <= 1'b0;
        end
    end
`else
    assign load_c = pc_enable_I;
`endif

    // PC register and valid flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_O       <= RESET_VECTOR;
            pc_valid_O <= 1'b0;
        end else begin
            pc_valid_O <= 1'b1;
            if (load_c) begin
                pc_O <= next_pc_I;
            end
        end
    end

    assign pc_plus4_O = pc_O + XLEN'(PC_STEP);

endmodule : jpc_pc

// File: tb/tb_jpc_pc.sv
// Self-checking bench for jpc_pc: directed vector table, hand-written
// stall/reset sequences, then randomized traffic against a reference model.
module tb_jpc_pc;

    localparam logic [31:0] RV = 32'h0000_0000;
`ifdef JPC_PC_MISALIGN_CHECK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [31:0] next_pc_I;
    logic        pc_enable_I;
    logic [31:0] pc_O;
    logic [31:0] pc_plus4_O;
    logic        pc_valid_O;
`ifdef JPC_PC_MISALIGN_CHECK_EN
    logic        misalign_O;
    logic [31:0] fault_pc_O;
`endif

    int total = 0;
    int bad   = 0;

    jpc_pc #(
        .XLEN         (32),
        .RESET_VECTOR (RV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .next_pc_I   (next_pc_I),
        .pc_enable_I (pc_enable_I),
        .pc_O        (pc_O),
        .pc_plus4_O  (pc_plus4_O),
        .pc_valid_O  (pc_valid_O)
`ifdef JPC_PC_MISALIGN_CHECK_EN
        ,
        .misalign_O  (misalign_O),
        .fault_pc_O  (fault_pc_O)
`endif
    );

    // Rising edges at 10, 20, 30 ... ns.
    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] pc, input logic valid,
                             input logic mis, input logic [31:0] fault);
        logic [31:0] p4;
        p4 = pc + 32'd4;
        check({tag, ".pc"}, pc_O, pc);
        check({tag, ".pc4"}, pc_plus4_O, p4);
        check({tag, ".valid"}, 32'(pc_valid_O), 32'(valid));
`ifdef JPC_PC_MISALIGN_CHECK_EN
        check({tag, ".mis"}, 32'(misalign_O), 32'(mis));
        check({tag, ".fault"}, fault_pc_O, fault);
`else
        if (mis || (fault != 32'h0)) begin end
`endif
    endtask

    typedef struct {
        logic        en;
        logic [31:0] npc;
        logic [31:0] pc;
        logic [31:0] p4;
        logic        mis;
        logic [31:0] fault;
    } vec_t;

    vec_t vecs[12];

    // Reference model state.
    logic [31:0] pc_m;
    logic        valid_m;
    logic        mis_m;
    logic [31:0] fault_m;

    task automatic model_edge(input logic en, input logic [31:0] npc);
        valid_m = 1'b1;
        if (en) begin
            if (MIS_EN && (npc % 4 != 0)) begin
                mis_m   = 1'b1;
                fault_m = npc;
            end else begin
                pc_m  = npc;
                mis_m = 1'b0;
            end
        end else begin
            mis_m = 1'b0;
        end
    endtask

    task automatic model_reset();
        pc_m    = RV;
        valid_m = 1'b0;
        mis_m   = 1'b0;
        fault_m = 32'h0;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 32'h0000_0004, 32'h0000_0004, 32'h0000_0008, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 32'h0000_0008, 32'h0000_0008, 32'h0000_000C, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, 32'h0000_0100, 32'h0000_0100, 32'h0000_0104, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, 32'h0000_0200, 32'h0000_0100, 32'h0000_0104, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 32'h0000_0200, 32'h0000_0100, 32'h0000_0104, 1'b0, 32'h0};
        vecs[5]  = '{1'b1, 32'h0000_0104, 32'h0000_0104, 32'h0000_0108, 1'b0, 32'h0};
        vecs[6]  = '{1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000, 1'b0, 32'h0};
        vecs[7]  = '{1'b0, 32'h0000_0000, 32'hFFFF_FFFC, 32'h0000_0000, 1'b0, 32'h0};
        vecs[8]  = '{1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0004, 1'b0, 32'h0};
`ifdef JPC_PC_MISALIGN_CHECK_EN
        vecs[9]  = '{1'b1, 32'h0000_0102, 32'h0000_0000, 32'h0000_0004, 1'b1, 32'h102};
        vecs[10] = '{1'b0, 32'h0000_0055, 32'h0000_0000, 32'h0000_0004, 1'b0, 32'h102};
        vecs[11] = '{1'b1, 32'h0000_0200, 32'h0000_0200, 32'h0000_0204, 1'b0, 32'h102};
`else
        vecs[9]  = '{1'b1, 32'h0000_0102, 32'h0000_0102, 32'h0000_0106, 1'b0, 32'h0};
        vecs[10] = '{1'b0, 32'h0000_0055, 32'h0000_0102, 32'h0000_0106, 1'b0, 32'h0};
        vecs[11] = '{1'b1, 32'h0000_0200, 32'h0000_0200, 32'h0000_0204, 1'b0, 32'h0};
`endif

        // Reset held from time zero; outputs must be clean before any edge.
        rst         = 1'b0;
        pc_enable_I = 1'b0;
        next_pc_I   = 32'hDEAD_BEEF;
        #20;
        check_all("reset", RV, 1'b0, 1'b0, 32'h0);
        #5;
        rst = 1'b1;

        // Directed table.
        for (int i = 0; i < 12; i++) begin
            pc_enable_I = vecs[i].en;
            next_pc_I   = vecs[i].npc;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d.pc", i), pc_O, vecs[i].pc);
            check($sformatf("vec%0d.pc4", i), pc_plus4_O, vecs[i].p4);
            check($sformatf("vec%0d.valid", i), 32'(pc_valid_O), 32'h1);
`ifdef JPC_PC_MISALIGN_CHECK_EN
            check($sformatf("vec%0d.mis", i), 32'(misalign_O), 32'(vecs[i].mis));
            check($sformatf("vec%0d.fault", i), fault_pc_O, vecs[i].fault);
`endif
        end

        // next_pc_I wiggling between edges must not reach pc_O.
        pc_enable_I = 1'b1;
        next_pc_I   = 32'h0000_0300;
        #2;
        check("between_edges_a", pc_O, 32'h0000_0200);
        next_pc_I = 32'h0000_0404;
        #2;
        check("between_edges_b", pc_O, 32'h0000_0200);
        @(posedge clk);
        #1;
        check("between_edges_load", pc_O, 32'h0000_0404);

        // Reset asserted mid-cycle during a stall, held across an edge, released between edges.
        pc_enable_I = 1'b0;
        next_pc_I   = 32'h0000_0500;
        @(posedge clk);
        #1;
        check("stall_before_rst", pc_O, 32'h0000_0404);
        #3;
        rst = 1'b0;
        #1;
        check_all("async_rst", RV, 1'b0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        check_all("rst_held", RV, 1'b0, 1'b0, 32'h0);
        #3;
        rst = 1'b1;
        #1;
        check("valid_before_edge", 32'(pc_valid_O), 32'h0);
        @(posedge clk);
        #1;
        check_all("release_stalled", RV, 1'b1, 1'b0, 32'h0);
        pc_enable_I = 1'b1;
        next_pc_I   = 32'h0000_0010;
        @(posedge clk);
        #1;
        check_all("after_release_load", 32'h0000_0010, 1'b1, 1'b0, 32'h0);

        // Randomized traffic against the reference model.
        pc_m    = 32'h0000_0010;
        valid_m = 1'b1;
        mis_m   = 1'b0;
        fault_m = 32'h0;
        for (int n = 0; n < 400; n++) begin
            logic        en;
            logic [31:0] npc;
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b0;
                #1;
                model_reset();
                check_all("rand_rst", pc_m, valid_m, mis_m, fault_m);
                rst = 1'b1;
            end
            en = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       npc = $urandom;
                1:       npc = pc_m + 32'd4;
                default: npc = $urandom & 32'hFFFF_FFFC;
            endcase
            pc_enable_I = en;
            next_pc_I   = npc;
            @(posedge clk);
            #1;
            model_edge(en, npc);
            check_all($sformatf("rand%0d", n), pc_m, valid_m, mis_m, fault_m);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_jpc_pc

// File: doc/jpc_pc.md
JPC_PC -- requirements
Module: jpc_pc

Interface
REQ-001 Parameter XLEN, default 32, address/PC width in bits.
REQ-002 Parameter RESET_VECTOR, default 32'h0000_0000, PC value loaded on reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low (0 = reset); deassertion takes effect at the next rising clk.
REQ-005 next_pc_I  input  XLEN  candidate next PC (sequential or branch/jump target).
REQ-006 pc_enable_I  input  1  1 = load next_pc_I at the clock edge; 0 = stall (hold).
REQ-007 pc_O  output  XLEN  current PC, registered.
REQ-008 pc_plus4_O  output  XLEN  combinational pc_O + 4, modulo 2^XLEN.
REQ-009 pc_valid_O  output  1  registered; 0 in reset, 1 from the first rising edge after rst deasserts.
REQ-010 misalign_O  output  1  registered alignment-fault pulse; present only when JPC_PC_MISALIGN_CHECK_EN is defined.
REQ-011 fault_pc_O  output  XLEN  registered offending target; present only when JPC_PC_MISALIGN_CHECK_EN is defined.

Function
REQ-012 At a rising edge with rst=1 and pc_enable_I=1, pc_O SHALL become next_pc_I; latency one cycle; no internal increment.
REQ-013 At a rising edge with pc_enable_I=0, pc_O SHALL hold its value for any number of cycles; next_pc_I is ignored.
REQ-014 pc_plus4_O SHALL wrap: pc_O=32'hFFFF_FFFC gives pc_plus4_O=32'h0000_0000; no carry out.
REQ-015 next_pc_I changing between edges SHALL NOT affect pc_O until the next enabled edge.
REQ-016 Branch targets (non-sequential next_pc_I) SHALL be loaded identically to sequential values; no distinction is made.
REQ-017 pc_valid_O SHALL rise on the first edge after reset release regardless of pc_enable_I and stay 1 until reset.

Reset
REQ-018 While rst=0: pc_O=RESET_VECTOR, pc_valid_O=0, misalign_O=0, fault_pc_O=0, all asynchronously, independent of clk.
REQ-019 Reset asserted mid-operation (including during a stall) SHALL override everything immediately; pc_O returns to RESET_VECTOR.
REQ-020 No X SHALL appear on any output after reset assertion.

Configuration
REQ-021 Macro JPC_PC_MISALIGN_CHECK_EN compiled in: at an enabled edge with next_pc_I[1:0]!=0, pc_O SHALL hold, misalign_O SHALL be 1 for exactly that following cycle, fault_pc_O SHALL capture next_pc_I; an aligned enabled load clears misalign_O; a stalled edge clears misalign_O and holds fault_pc_O.
REQ-022 Macro not defined: misalign_O and fault_pc_O ports are absent, and any next_pc_I (including unaligned) loads per REQ-012.

Structure
REQ-023 Shared package jpc_pkg SHALL hold XLEN default, RESET_VECTOR default, constant PC_STEP=4 and the alignment-mask constant.
REQ-024 Alignment check SHALL be a sub-module jpc_pc_align_chk (combinational, input address, output fault flag), instantiated only under the macro.

Verification
REQ-025 rst=0 for 25 ns, then rst=1, pc_enable_I=1, next_pc_I=pc_O+4 each cycle -> pc_O 0x0, 0x4, 0x8 on successive edges; pc_valid_O=1 after the first edge.
REQ-026 next_pc_I=32'h100, enable=1 -> pc_O=0x100 one edge later; pc_plus4_O=0x104.
REQ-027 pc_enable_I=0 for 2 cycles with next_pc_I=0x200 -> pc_O stays 0x100; re-enable with next_pc_I=0x104 -> pc_O=0x104.
REQ-028 rst driven 0 between clock edges while pc_O=0x104 -> pc_O=RESET_VECTOR before the next edge; pc_valid_O=0.
REQ-029 pc_O loaded with 32'hFFFF_FFFC -> pc_plus4_O=0x0.
REQ-030 With JPC_PC_MISALIGN_CHECK_EN, next_pc_I=0x102, enable=1 -> pc_O holds, misalign_O=1 for one cycle, fault_pc_O=0x102; without the macro -> pc_O=0x102.
